// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment codes are active low, bit order g..a (seg[0]=a, seg[6]=g).
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] ANODES_OFF = 4'b1111;

    localparam int unsigned IDX_W = 2;

    // Slot order on the display: units first, thousands last.
    typedef enum logic [IDX_W-1:0] {
        IDX_UNITS = 2'd0,
        IDX_TENS  = 2'd1,
        IDX_HUND  = 2'd2,
        IDX_THOUS = 2'd3
    } idx_t;

    // One frame's worth of latched display content.
    typedef struct packed {
        logic [3:0] thous;
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] units;
        logic [3:0] dp_en;
    } snap_t;

    // Active-low one-cold anode pattern for a slot.
    function automatic logic [3:0] anode_sel(input idx_t i);
        logic [3:0] onehot;
        onehot = 4'b0001 << i;
        return ~onehot;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; invalid codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg = SEG_DASH;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with per-slot blanking
// gap and a once-per-frame snapshot of the displayed digits.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] thous,
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic [3:0] dp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned     CNT_W     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    idx_t             idx;
    snap_t            snap;

    logic             cnt_wrap;
    logic             snap_take;
    logic             blank_win;
    logic             suppress;
    logic [3:0]       cur_digit;
    logic             cur_dp;
    logic [6:0]       cur_seg;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    // Slot timing and snapshot instant.
    always_comb begin
        cnt_wrap  = (cnt == CNT_LAST);
        snap_take = (cnt == '0) && (idx == IDX_UNITS);
        blank_win = (cnt < BLANK_END);
    end

    // Select the snapshot digit and decimal-point request for the current slot.
    always_comb begin
        cur_digit = snap.units;
        cur_dp    = snap.dp_en[0];
        unique case (idx)
            IDX_UNITS: begin cur_digit = snap.units; cur_dp = snap.dp_en[0]; end
            IDX_TENS:  begin cur_digit = snap.tens;  cur_dp = snap.dp_en[1]; end
            IDX_HUND:  begin cur_digit = snap.hund;  cur_dp = snap.dp_en[2]; end
            IDX_THOUS: begin cur_digit = snap.thous; cur_dp = snap.dp_en[3]; end
            default:   begin cur_digit = snap.units; cur_dp = snap.dp_en[0]; end
        endcase
    end

    // Decide whether the current slot is a leading zero to be kept dark.
    always_comb begin
        suppress = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        unique case (idx)
            IDX_THOUS: suppress = (snap.thous == 4'd0);
            IDX_HUND:  suppress = (snap.thous == 4'd0) && (snap.hund == 4'd0);
            IDX_TENS:  suppress = (snap.thous == 4'd0) && (snap.hund == 4'd0)
                                && (snap.tens == 4'd0);
            default:   suppress = 1'b0;
        endcase
`endif
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // Next output pattern: dark during the blank window or a suppressed slot.
    always_comb begin
        an_next  = ANODES_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (!blank_win && !suppress) begin
            an_next  = anode_sel(idx);
            seg_next = cur_seg;
            dp_next  = ~cur_dp;
        end
    end

    // Scan counter, slot index, frame snapshot and registered outputs.
    // The snapshot is written at cnt==0 of slot 0 while outputs are still in
    // the blank window, so the new frame's content is in place before any
    // digit of that frame is lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            idx  <= IDX_UNITS;
            snap <= '0;
            an   <= ANODES_OFF;
            seg  <= SEG_OFF;
            dp   <= 1'b1;
        end else begin
            if (cnt_wrap) begin
                cnt <= '0;
                idx <= idx_t'(idx + 2'd1);
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (snap_take) begin
                snap <= '{thous: thous, hund: hund, tens: tens, units: units, dp_en: dp_en};
            end
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DWELL_CYCLES=20, BLANK_CYCLES=2).
// Expected outputs come from a frame-position model of the display; a
// separate monitor compares every cycle. Honours SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_driver;

    localparam int unsigned DWELL = 20;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 4 * DWELL;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    localparam logic [6:0] DEC [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clk;
    logic       reset;
    logic [3:0] thous, hund, tens, units, dp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg7_scan_driver #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .thous (thous),
        .hund  (hund),
        .tens  (tens),
        .units (units),
        .dp_en (dp_en),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    out_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;

    // Model state: edges since reset release (mod frame) and the frame's digits.
    int unsigned m_pos = 0;
    logic [3:0]  m_dig [4];
    logic        m_dpe [4];

    function automatic logic [6:0] decode(input logic [3:0] d);
        if (d > 4'd9) return 7'b0111111;
        return DEC[d];
    endfunction

    // One clock: drive inputs before the edge and queue what the display must show after it.
    task automatic step(input logic rst, input logic [3:0] th, input logic [3:0] hu,
                        input logic [3:0] te, input logic [3:0] un, input logic [3:0] dpe);
        out_t        e;
        int unsigned slot, off;
        logic        dark;
        @(negedge clk);
        reset = rst; thous = th; hund = hu; tens = te; units = un; dp_en = dpe;
        e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
        if (rst) begin
            m_pos = 0;
            for (int i = 0; i < 4; i++) begin m_dig[i] = 4'd0; m_dpe[i] = 1'b0; end
        end else begin
            if (m_pos == 0) begin
                m_dig[0] = un; m_dig[1] = te; m_dig[2] = hu; m_dig[3] = th;
                for (int i = 0; i < 4; i++) m_dpe[i] = dpe[i];
            end
            slot = m_pos / DWELL;
            off  = m_pos % DWELL;
            dark = (off < BLANK);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (slot > 0) begin
                logic all_zero;
                all_zero = 1'b1;
                for (int j = int'(slot); j < 4; j++) if (m_dig[j] != 4'd0) all_zero = 1'b0;
                if (all_zero) dark = 1'b1;
            end
`endif
            if (!dark) begin
                e.an       = 4'b1111;
                e.an[slot] = 1'b0;
                e.seg      = decode(m_dig[slot]);
                e.dp       = ~m_dpe[slot];
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic [3:0] th, input logic [3:0] hu,
                       input logic [3:0] te, input logic [3:0] un, input logic [3:0] dpe);
        for (int i = 0; i < n; i++) step(1'b0, th, hu, te, un, dpe);
    endtask

    // Monitor: compare the registered outputs just after every active edge.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty: got an=%b seg=%b dp=%b, no expectation queued",
                         an, seg, dp);
            end else begin
                e = exp_q.pop_front();
                if ({an, seg, dp} !== e) begin
                    fails++;
                    $display("FAIL scan_out @%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                             $time, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r_th, r_hu, r_te, r_un, r_dp;
        reset = 1'b1; thous = '0; hund = '0; tens = '0; units = '0; dp_en = '0;

        // Reset held, released with 0150; first full frame.
        for (int i = 0; i < 5; i++) step(1'b1, 4'd0, 4'd1, 4'd5, 4'd0, 4'b0000);
        run(FRAME, 4'd0, 4'd1, 4'd5, 4'd0, 4'b0000);

        // Input changes during the tens slot appear only in the next frame.
        run(30, 4'd0, 4'd1, 4'd5, 4'd0, 4'b0000);
        run(50 + FRAME, 4'd0, 4'd1, 4'd5, 4'd1, 4'b0000);

        // Invalid BCD on units with its decimal point requested.
        run(FRAME, 4'd0, 4'd1, 4'd5, 4'hA, 4'b0001);

        // Reset pulse during the hundreds slot, then a fresh scan.
        run(45, 4'd3, 4'd4, 4'd2, 4'd8, 4'b1010);
        step(1'b1, 4'd9, 4'd8, 4'd7, 4'd6, 4'b0100);
        run(FRAME + 20, 4'd9, 4'd8, 4'd7, 4'd6, 4'b0100);

        // Leading-zero patterns.
        run(FRAME, 4'd0, 4'd0, 4'd0, 4'd7, 4'b0000);
        run(FRAME, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1111);
        run(FRAME, 4'd0, 4'd0, 4'd4, 4'd0, 4'b0000);
        run(FRAME, 4'd0, 4'd3, 4'd0, 4'd0, 4'b0000);

        // Random digits, decimal points and occasional resets.
        r_th = 4'd1; r_hu = 4'd2; r_te = 4'd3; r_un = 4'd4; r_dp = 4'd0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                r_th = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                r_hu = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                r_te = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                r_un = 4'($urandom_range(0, 15));
                r_dp = 4'($urandom_range(0, 15));
            end
            step(($urandom_range(0, 299) == 0), r_th, r_hu, r_te, r_un, r_dp);
        end

        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
